// File: rtl/ae350_rst_pkg.sv
// Shared state encoding and output decode for the AE350 reset sequencer.
package ae350_rst_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_DDR_INIT  = 3'd2,
        S_POR       = 3'd3,
        S_HW        = 3'd4,
        S_RUN       = 3'd5,
        S_FAIL      = 3'd6
    } rst_state_e;

    typedef struct packed {
        logic ddr_rstn;
        logic por_rstn;
        logic hw_rstn;
        logic sys_ready;
        logic fail;
    } rst_out_t;

    // Reset releases are cumulative along the sequence, so ordering holds by construction.
    function automatic rst_out_t state_outputs(input rst_state_e s);
        rst_out_t o;
        o = '0;
        case (s)
            S_DDR_INIT: o.ddr_rstn = 1'b1;
            S_POR:      o.ddr_rstn = 1'b1;
            S_HW: begin
                o.ddr_rstn = 1'b1;
                o.por_rstn = 1'b1;
            end
            S_RUN: begin
                o.ddr_rstn  = 1'b1;
                o.por_rstn  = 1'b1;
                o.hw_rstn   = 1'b1;
                o.sys_ready = 1'b1;
            end
            S_FAIL:     o.fail = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rst_key_filter.sv
// Reset key synchroniser and debouncer: key_press pulses once per debounced press,
// key_held stays high until the key has been stably released.
module rst_key_filter #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_rstn,
    output logic key_press,
    output logic key_held
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]    sync_reg;
    logic [DW-1:0] cnt_reg;
    logic          held_reg;
    logic          press_reg;
    logic          key_s;
    logic          moving;

    assign key_s = sync_reg[1];
    // The key is heading away from the debounced level whenever its raw level equals held_reg.
    assign moving = (key_s == held_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            cnt_reg   <= '0;
            held_reg  <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_rstn};
            press_reg <= 1'b0;
            if (!moving) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
                cnt_reg   <= '0;
                held_reg  <= ~held_reg;
                press_reg <= ~held_reg;
            end else begin
                cnt_reg <= cnt_reg + DW'(1);
            end
        end
    end

    assign key_press = press_reg;
    assign key_held  = held_reg;

endmodule

// File: rtl/ae350_reset_sequencer.sv
// Power-up / reset sequencer: PLL lock, DDR3 init with bounded retries, then POR and HW reset release.
module ae350_reset_sequencer #(
    parameter int DEBOUNCE_CYC    = 1_000_000,
    parameter int RESET_HOLD_CYC  = 64,
    parameter int DDR_TIMEOUT_CYC = 50_000_000,
    parameter int POR_HOLD_CYC    = 1024,
    parameter int HW_LAG_CYC      = 256,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 26
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       key_rstn,
    input  logic       pll_lock,
    input  logic       ddr_init_done,
    output logic       ddr_rstn,
    output logic       por_rstn,
    output logic       hw_rstn,
    output logic       sys_ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    import ae350_rst_pkg::*;

    localparam int N_ASYNC = 2;

    logic [1:0]         rst_sync_reg;
    logic               rst_n;
    logic [N_ASYNC-1:0] async_in;
    logic [N_ASYNC-1:0] async_sync;
    logic               lock_s;
    logic               init_s;
    logic               key_press;
    logic               key_held;

    rst_state_e         state_reg;
    rst_state_e         state_next;
    logic [1:0]         retry_reg;
    logic [1:0]         retry_next;
    logic [1:0]         retry_inc;
    logic [CNT_W-1:0]   phase_cnt_reg;
    logic               cnt_clr;
    logic               lock_loss;
    logic               init_loss;
    rst_out_t           out_reg;

    // Assert asynchronously, release only after two clean CLK edges.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_reg[1];

    assign async_in = {ddr_init_done, pll_lock};

    genvar gi;
    generate
        for (gi = 0; gi < N_ASYNC; gi++) begin : g_sync
            logic [1:0] sync_reg;
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], async_in[gi]};
                end
            end
            assign async_sync[gi] = sync_reg[1];
        end
    endgenerate

    assign lock_s = async_sync[0];
    assign init_s = async_sync[1];

    rst_key_filter #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_filter (
        .clk       (CLK),
        .rst_n     (rst_n),
        .key_rstn  (key_rstn),
        .key_press (key_press),
        .key_held  (key_held)
    );

    assign lock_loss = !lock_s && (state_reg inside {S_DDR_INIT, S_POR, S_HW, S_RUN});
    assign init_loss = !init_s && (state_reg inside {S_POR, S_HW, S_RUN});
    assign retry_inc = retry_reg + 2'd1;

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        if (key_press) begin
            state_next = S_RESET;
            retry_next = '0;
        end else if (lock_loss || init_loss) begin
            state_next = S_RESET;
        end else begin
            case (state_reg)
                S_RESET: begin
                    if (phase_cnt_reg >= CNT_W'(RESET_HOLD_CYC - 1) && !key_held)
                        state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s)
                        state_next = S_DDR_INIT;
                end
                S_DDR_INIT: begin
                    // Init completion wins over a timeout landing on the same cycle.
                    if (init_s) begin
                        state_next = S_POR;
                    end else if (phase_cnt_reg == CNT_W'(DDR_TIMEOUT_CYC - 1)) begin
                        retry_next = retry_inc;
                        state_next = (retry_inc == 2'(MAX_RETRY)) ? S_FAIL : S_RESET;
                    end
                end
                S_POR: begin
                    if (phase_cnt_reg == CNT_W'(POR_HOLD_CYC - 1))
                        state_next = S_HW;
                end
                S_HW: begin
                    if (phase_cnt_reg == CNT_W'(HW_LAG_CYC - 1)) begin
                        state_next = S_RUN;
                        retry_next = '0;
                    end
                end
                S_RUN:   state_next = S_RUN;
                S_FAIL:  state_next = S_FAIL;
                default: state_next = S_RESET;
            endcase
        end
    end

    assign cnt_clr = key_press || (state_next != state_reg);

    // Outputs are decoded from state_next so they switch on the same edge as state_reg.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_RESET;
            retry_reg     <= '0;
            phase_cnt_reg <= '0;
            out_reg       <= '0;
        end else begin
            state_reg <= state_next;
            retry_reg <= retry_next;
            out_reg   <= state_outputs(state_next);
            if (cnt_clr) begin
                phase_cnt_reg <= '0;
            end else if (phase_cnt_reg != '1) begin
                phase_cnt_reg <= phase_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign ddr_rstn  = out_reg.ddr_rstn;
    assign por_rstn  = out_reg.por_rstn;
    assign hw_rstn   = out_reg.hw_rstn;
    assign sys_ready = out_reg.sys_ready;
    assign fail      = out_reg.fail;
    assign retry_cnt = retry_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_ae350_reset_sequencer.sv
// Scenario bench for ae350_reset_sequencer: state-change scoreboard plus per-scenario timing checks.
module tb_ae350_reset_sequencer;

    localparam int DEB  = 8;
    localparam int HOLD = 4;
    localparam int TMO  = 100;
    localparam int PORH = 16;
    localparam int LAG  = 4;
    localparam int MAXR = 3;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b1;
    logic       key_rstn = 1'b1;
    logic       pll_lock = 1'b0;
    logic       ddr_init_done = 1'b0;
    logic       ddr_rstn, por_rstn, hw_rstn, sys_ready, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       ddr;
        logic       por;
        logic       hw;
        logic       rdy;
        logic       fl;
        logic [1:0] rc;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] last_st = 3'd0;
    bit         mon_en = 1'b0;

    ae350_reset_sequencer #(
        .DEBOUNCE_CYC    (DEB),
        .RESET_HOLD_CYC  (HOLD),
        .DDR_TIMEOUT_CYC (TMO),
        .POR_HOLD_CYC    (PORH),
        .HW_LAG_CYC      (LAG),
        .MAX_RETRY       (MAXR),
        .CNT_W           (26)
    ) dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .key_rstn      (key_rstn),
        .pll_lock      (pll_lock),
        .ddr_init_done (ddr_init_done),
        .ddr_rstn      (ddr_rstn),
        .por_rstn      (por_rstn),
        .hw_rstn       (hw_rstn),
        .sys_ready     (sys_ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .state_dbg     (state_dbg)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t mk_exp(input logic [2:0] s, input logic [1:0] rc);
        exp_t e;
        e.st  = s;
        e.ddr = (s >= 3'd2) && (s <= 3'd5);
        e.por = (s == 3'd4) || (s == 3'd5);
        e.hw  = (s == 3'd5);
        e.rdy = (s == 3'd5);
        e.fl  = (s == 3'd6);
        e.rc  = rc;
        return e;
    endfunction

    task automatic push(input logic [2:0] s, input logic [1:0] rc);
        exp_q.push_back(mk_exp(s, rc));
    endtask

    // Scoreboard: every observed state change pops one expectation.
    always @(negedge CLK) begin
        exp_t e;
        exp_t got;
        if (mon_en) begin
            if (state_dbg !== last_st) begin
                last_st = state_dbg;
                checks++;
                got = {state_dbg, ddr_rstn, por_rstn, hw_rstn, sys_ready, fail, retry_cnt};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: cyc=%0d state_dbg=%0d with no pending expectation", cyc, state_dbg);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL sb_state: cyc=%0d got st=%0d ddr=%b por=%b hw=%b rdy=%b fl=%b rc=%0d, required st=%0d ddr=%b por=%b hw=%b rdy=%b fl=%b rc=%0d",
                                 cyc, got.st, got.ddr, got.por, got.hw, got.rdy, got.fl, got.rc,
                                 e.st, e.ddr, e.por, e.hw, e.rdy, e.fl, e.rc);
                    end else begin
                        $display("sb ok: cyc=%0d state=%0d ddr=%b por=%b hw=%b rdy=%b fl=%b retry=%0d",
                                 cyc, got.st, got.ddr, got.por, got.hw, got.rdy, got.fl, got.rc);
                    end
                end
            end
            checks++;
            if ((por_rstn && !ddr_rstn) || (hw_rstn && !por_rstn)) begin
                errors++;
                $display("FAIL reset_order: cyc=%0d ddr=%b por=%b hw=%b", cyc, ddr_rstn, por_rstn, hw_rstn);
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget, output int at);
        at = -1000;
        checks++;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (state_dbg === s) begin
                at = cyc;
                return;
            end
        end
        errors++;
        $display("FAIL wait_state: state_dbg=%0d, required %0d within %0d cycles", state_dbg, s, budget);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b0;
        #1;
        checks++;
        if ({ddr_rstn, por_rstn, hw_rstn, sys_ready, fail} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", {ddr_rstn, por_rstn, hw_rstn, sys_ready, fail});
        end
        checks++;
        if (state_dbg !== 3'd0 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d retry=%0d required 0/0", state_dbg, retry_cnt);
        end
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
        last_st = 3'd0;
        mon_en = 1'b1;
        $display("reset: applied and released at cyc=%0d", cyc);
    endtask

    task automatic test_nominal();
        int t3, t4, t5;
        push(3'd1, 2'd0); push(3'd2, 2'd0); push(3'd3, 2'd0); push(3'd4, 2'd0); push(3'd5, 2'd0);
        repeat (10) @(posedge CLK);
        #1 pll_lock = 1'b1;
        repeat (40) @(posedge CLK);
        #1 ddr_init_done = 1'b1;
        wait_state(3'd3, 50, t3);
        wait_state(3'd4, 50, t4);
        checks++;
        if (t4 - t3 != PORH) begin
            errors++;
            $display("FAIL por_hold: got %0d cycles required %0d", t4 - t3, PORH);
        end
        wait_state(3'd5, 50, t5);
        checks++;
        if (t5 - t4 != LAG) begin
            errors++;
            $display("FAIL hw_lag: got %0d cycles required %0d", t5 - t4, LAG);
        end
        $display("nominal: por entry %0d, hw entry %0d, run entry %0d", t3, t4, t5);
    endtask

    task automatic test_key_glitch();
        @(posedge CLK);
        #1 key_rstn = 1'b0;
        repeat (5) @(posedge CLK);
        #1 key_rstn = 1'b1;
        repeat (30) @(negedge CLK);
        checks++;
        if (state_dbg !== 3'd5 || sys_ready !== 1'b1) begin
            errors++;
            $display("FAIL key_glitch: state=%0d sys_ready=%b required 5/1", state_dbg, sys_ready);
        end
        $display("key_glitch: 5-cycle glitch applied, state=%0d", state_dbg);
    endtask

    task automatic test_lock_loss();
        int t;
        push(3'd0, 2'd0); push(3'd1, 2'd0); push(3'd2, 2'd0);
        push(3'd3, 2'd0); push(3'd4, 2'd0); push(3'd5, 2'd0);
        @(posedge CLK);
        #1 pll_lock = 1'b0;
        @(posedge CLK);
        #1 pll_lock = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (state_dbg !== 3'd0 || {ddr_rstn, por_rstn, hw_rstn} !== 3'b000) begin
            errors++;
            $display("FAIL lock_loss_reset: state=%0d resets=%b required 0/000", state_dbg, {ddr_rstn, por_rstn, hw_rstn});
        end
        checks++;
        if (retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL lock_loss_retry: got %0d required 0", retry_cnt);
        end
        wait_state(3'd5, 200, t);
        $display("lock_loss: recovered to run at cyc=%0d", t);
    endtask

    task automatic test_timeout_boundary();
        int t0, t2, t3, t5;
        push(3'd0, 2'd0); push(3'd1, 2'd0); push(3'd2, 2'd0);
        push(3'd3, 2'd0); push(3'd4, 2'd0); push(3'd5, 2'd0);
        @(posedge CLK);
        #1 ddr_init_done = 1'b0;
        wait_state(3'd0, 10, t0);
        wait_state(3'd2, 20, t2);
        // Raw rise 97 edges after entry reaches the FSM on the cycle the counter hits TMO-1.
        repeat (TMO - 3) @(posedge CLK);
        #1 ddr_init_done = 1'b1;
        wait_state(3'd3, 10, t3);
        checks++;
        if (t3 - t2 != TMO) begin
            errors++;
            $display("FAIL timeout_tie_time: ddr_init lasted %0d cycles required %0d", t3 - t2, TMO);
        end
        checks++;
        if (retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL timeout_tie_retry: got %0d required 0", retry_cnt);
        end
        wait_state(3'd5, 100, t5);
        $display("timeout_tie: por entered at cyc=%0d, retry=%0d", t3, retry_cnt);
    endtask

    task automatic test_ddr_fail();
        int t, t2, te;
        push(3'd0, 2'd0);
        for (int k = 1; k <= MAXR; k++) begin
            push(3'd1, 2'(k - 1));
            push(3'd2, 2'(k - 1));
            push((k < MAXR) ? 3'd0 : 3'd6, 2'(k));
        end
        @(posedge CLK);
        #1 ddr_init_done = 1'b0;
        wait_state(3'd0, 10, t);
        for (int k = 1; k <= MAXR; k++) begin
            wait_state(3'd2, 20, t2);
            wait_state((k < MAXR) ? 3'd0 : 3'd6, TMO + 20, te);
            checks++;
            if (te - t2 != TMO) begin
                errors++;
                $display("FAIL ddr_timeout_len: attempt %0d lasted %0d required %0d", k, te - t2, TMO);
            end
            checks++;
            if (retry_cnt !== 2'(k)) begin
                errors++;
                $display("FAIL ddr_retry_cnt: attempt %0d got %0d required %0d", k, retry_cnt, k);
            end
            $display("ddr_fail: attempt %0d timed out at cyc=%0d retry=%0d", k, te, retry_cnt);
        end
        repeat (300) @(negedge CLK);
        checks++;
        if (state_dbg !== 3'd6 || fail !== 1'b1 || {ddr_rstn, por_rstn, hw_rstn} !== 3'b000 || retry_cnt !== 2'd3) begin
            errors++;
            $display("FAIL fail_hold: state=%0d fail=%b resets=%b retry=%0d required 6/1/000/3",
                     state_dbg, fail, {ddr_rstn, por_rstn, hw_rstn}, retry_cnt);
        end
    endtask

    task automatic test_fail_exit();
        int t0, t1, t5;
        push(3'd0, 2'd0); push(3'd1, 2'd0); push(3'd2, 2'd0);
        push(3'd3, 2'd0); push(3'd4, 2'd0); push(3'd5, 2'd0);
        @(posedge CLK);
        #1 key_rstn = 1'b0;
        repeat (DEB) @(posedge CLK);
        #1 key_rstn = 1'b1;
        ddr_init_done = 1'b1;
        wait_state(3'd0, 20, t0);
        checks++;
        if (retry_cnt !== 2'd0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL fail_exit: retry=%0d fail=%b required 0/0", retry_cnt, fail);
        end
        wait_state(3'd1, 40, t1);
        checks++;
        if (t1 - t0 < HOLD + 1 || t1 - t0 > DEB + HOLD) begin
            errors++;
            $display("FAIL key_release_gate: reset dwell %0d cycles required %0d..%0d", t1 - t0, HOLD + 1, DEB + HOLD);
        end
        wait_state(3'd5, 100, t5);
        $display("fail_exit: reset at cyc=%0d, restart at cyc=%0d, run at cyc=%0d", t0, t1, t5);
    endtask

    task automatic test_async_reset();
        int t;
        push(3'd0, 2'd0); push(3'd1, 2'd0); push(3'd2, 2'd0);
        push(3'd3, 2'd0); push(3'd4, 2'd0);
        @(posedge CLK);
        #1 ddr_init_done = 1'b0;
        wait_state(3'd0, 10, t);
        @(posedge CLK);
        #1 ddr_init_done = 1'b1;
        wait_state(3'd4, 100, t);
        push(3'd0, 2'd0);
        #2 RSTN = 1'b0;
        #1;
        checks++;
        if ({ddr_rstn, por_rstn, hw_rstn, sys_ready, fail} !== 5'b0 || state_dbg !== 3'd0 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b state=%0d retry=%0d required 00000/0/0",
                     {ddr_rstn, por_rstn, hw_rstn, sys_ready, fail}, state_dbg, retry_cnt);
        end
        $display("async_reset: asserted during hw at cyc=%0d", cyc);
        push(3'd1, 2'd0); push(3'd2, 2'd0); push(3'd3, 2'd0); push(3'd4, 2'd0); push(3'd5, 2'd0);
        repeat (3) @(posedge CLK);
        #1 RSTN = 1'b1;
        wait_state(3'd5, 200, t);
        $display("async_reset: back in run at cyc=%0d", t);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_key_glitch();
        test_lock_loss();
        test_timeout_boundary();
        test_ddr_fail();
        test_fail_exit();
        test_async_reset();
        repeat (5) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending: %0d expected transitions never observed", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
